// File: rtl/epu_buf_pkg.sv
// Shared types and constants for the EPU buffer responder and its storage array.
package epu_buf_pkg;

  localparam int BYTE_W = 8;
  localparam int NBYTE  = 4;

  // Zero-fill sequencer states.
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  // Which master drives the array in the current cycle.
  typedef enum logic [1:0] {
    OWN_CLR  = 2'd0,
    OWN_COMP = 2'd1,
    OWN_HOST = 2'd2
  } owner_e;

endpackage

// File: rtl/epu_buf_array.sv
// Behavioural single-port DEPTH x 32 storage with per-byte write enables and a
// registered read port. Drop-in replaceable by an SRAM macro wrapper.
module epu_buf_array
  import epu_buf_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    cs,
  input  logic                    we,
  input  logic [AW-1:0]           addr,
  input  logic [NBYTE-1:0]        bweb,
  input  logic [NBYTE*BYTE_W-1:0] d,
  output logic [NBYTE*BYTE_W-1:0] q
);

  logic [NBYTE*BYTE_W-1:0] mem [DEPTH];

  // Byte-masked write commits at the edge; reads register the addressed word.
  // No reset: contents and q are undefined until written/read.
  always_ff @(posedge clk) begin
    if (cs) begin
      if (we) begin
        for (int b = 0; b < NBYTE; b++) begin
          if (bweb[b]) begin
            mem[addr][b*BYTE_W +: BYTE_W] <= d[b*BYTE_W +: BYTE_W];
          end
        end
      end else begin
        q <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/epu_buf_responder.sv
// Memory-side responder for one EPU buffer: arbitrates the zero-fill sequencer,
// the compute engine (no stall path) and a host/DMA valid/ready port onto one
// single-port array, and steers read data back to whichever port asked for it.
module epu_buf_responder
  import epu_buf_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          busy,
  input  logic          c_cs,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [3:0]    c_bweb,
  input  logic [31:0]   c_d,
  output logic [31:0]   c_q,
  input  logic          h_valid,
  output logic          h_ready,
  input  logic          h_we,
  input  logic [AW-1:0] h_addr,
  input  logic [3:0]    h_bweb,
  input  logic [31:0]   h_d,
  output logic          h_rvalid,
  output logic [31:0]   h_rdata,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          clr_done
);

  clr_state_e    state_reg, state_next;
  logic [AW-1:0] clr_ptr_reg, clr_ptr_next;
  logic          clr_done_reg, clr_done_next;

  owner_e        owner;
  logic          arr_cs;
  logic          arr_we;
  logic [AW-1:0] arr_addr;
  logic [3:0]    arr_bweb;
  logic [31:0]   arr_d;
  logic [31:0]   arr_q;

  // Owner tags for reads launched last cycle, plus holding registers so each
  // port keeps its last read value while the other port uses the array.
  logic          comp_rd_reg;
  logic          host_rd_reg;
  logic [31:0]   c_hold_reg;
  logic [31:0]   h_hold_reg;

  // Zero-fill sequencer state, sweep pointer and done pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg    <= IDLE;
      clr_ptr_reg  <= '0;
      clr_done_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      clr_ptr_reg  <= clr_ptr_next;
      clr_done_reg <= clr_done_next;
    end
  end

  // Sweep one address per cycle; requests while busy or mid-sweep are dropped.
  always_comb begin
    state_next    = state_reg;
    clr_ptr_next  = clr_ptr_reg;
    clr_done_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (clr_req && !busy) begin
          state_next   = CLEAR;
          clr_ptr_next = '0;
        end
      end
      CLEAR: begin
        clr_ptr_next = clr_ptr_reg + 1'b1;
        if (clr_ptr_reg == AW'(DEPTH - 1)) begin
          state_next    = IDLE;
          clr_done_next = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Fixed-priority owner select and array input mux.
  always_comb begin
    if (state_reg == CLEAR) begin
      owner = OWN_CLR;
    end else if (busy) begin
      owner = OWN_COMP;
    end else begin
      owner = OWN_HOST;
    end

    arr_cs   = 1'b0;
    arr_we   = 1'b0;
    arr_addr = '0;
    arr_bweb = '0;
    arr_d    = '0;
    h_ready  = 1'b0;
    case (owner)
      OWN_CLR: begin
        arr_cs   = 1'b1;
        arr_we   = 1'b1;
        arr_addr = clr_ptr_reg;
        arr_bweb = 4'hF;
        arr_d    = 32'h0;
      end
      OWN_COMP: begin
        arr_cs   = c_cs;
        arr_we   = c_we;
        arr_addr = c_addr;
        arr_bweb = c_bweb;
        arr_d    = c_d;
      end
      OWN_HOST: begin
        h_ready  = h_valid;
        arr_cs   = h_valid;
        arr_we   = h_we;
        arr_addr = h_addr;
        arr_bweb = h_bweb;
        arr_d    = h_d;
      end
      default: begin
        arr_cs = 1'b0;
      end
    endcase
  end

  epu_buf_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk  (clk),
    .cs   (arr_cs),
    .we   (arr_we),
    .addr (arr_addr),
    .bweb (arr_bweb),
    .d    (arr_d),
    .q    (arr_q)
  );

  // Tag reads with their owner and latch returned data into per-port holds.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      comp_rd_reg <= 1'b0;
      host_rd_reg <= 1'b0;
      c_hold_reg  <= '0;
      h_hold_reg  <= '0;
    end else begin
      comp_rd_reg <= (owner == OWN_COMP) && c_cs && !c_we;
      host_rd_reg <= (owner == OWN_HOST) && h_valid && !h_we;
      if (comp_rd_reg) begin
        c_hold_reg <= arr_q;
      end
      if (host_rd_reg) begin
        h_hold_reg <= arr_q;
      end
    end
  end

  assign c_q      = comp_rd_reg ? arr_q : c_hold_reg;
  assign h_rdata  = host_rd_reg ? arr_q : h_hold_reg;
  assign h_rvalid = host_rd_reg;
  assign clr_busy = (state_reg == CLEAR);
  assign clr_done = clr_done_reg;

endmodule

// File: tb/tb_epu_buf_responder.sv
// Directed bench for epu_buf_responder with DEPTH = 16.
module tb_epu_buf_responder;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk;
  logic          rstn;
  logic          busy;
  logic          c_cs;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [3:0]    c_bweb;
  logic [31:0]   c_d;
  logic [31:0]   c_q;
  logic          h_valid;
  logic          h_ready;
  logic          h_we;
  logic [AW-1:0] h_addr;
  logic [3:0]    h_bweb;
  logic [31:0]   h_d;
  logic          h_rvalid;
  logic [31:0]   h_rdata;
  logic          clr_req;
  logic          clr_busy;
  logic          clr_done;

  int checks = 0;
  int errors = 0;

  epu_buf_responder #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .busy     (busy),
    .c_cs     (c_cs),
    .c_we     (c_we),
    .c_addr   (c_addr),
    .c_bweb   (c_bweb),
    .c_d      (c_d),
    .c_q      (c_q),
    .h_valid  (h_valid),
    .h_ready  (h_ready),
    .h_we     (h_we),
    .h_addr   (h_addr),
    .h_bweb   (h_bweb),
    .h_d      (h_d),
    .h_rvalid (h_rvalid),
    .h_rdata  (h_rdata),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change 1 time unit after the active edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [AW-1:0] addr, input logic [31:0] data);
    h_valid = 1'b1; h_we = 1'b1; h_addr = addr; h_bweb = 4'hF; h_d = data;
    cycle();
    h_valid = 1'b0; h_we = 1'b0;
    $display("host wr addr=%0d data=%h", addr, data);
  endtask

  task automatic host_read(input logic [AW-1:0] addr, output logic [31:0] data);
    h_valid = 1'b1; h_we = 1'b0; h_addr = addr;
    cycle();
    h_valid = 1'b0;
    data = h_rdata;
    $display("host rd addr=%0d data=%h rvalid=%0b", addr, data, h_rvalid);
  endtask

  task automatic test_reset();
    rstn = 1'b0; busy = 1'b0; c_cs = 1'b0; c_we = 1'b0; c_addr = '0; c_bweb = '0; c_d = '0;
    h_valid = 1'b0; h_we = 1'b0; h_addr = '0; h_bweb = '0; h_d = '0; clr_req = 1'b0;
    #22;
    checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL reset_clr_busy got=%b exp=0", clr_busy); end
    checks++; if (clr_done !== 1'b0) begin errors++; $display("FAIL reset_clr_done got=%b exp=0", clr_done); end
    checks++; if (h_rvalid !== 1'b0) begin errors++; $display("FAIL reset_h_rvalid got=%b exp=0", h_rvalid); end
    checks++; if (h_ready !== 1'b0) begin errors++; $display("FAIL reset_h_ready got=%b exp=0", h_ready); end
    checks++; if (c_q !== 32'h0) begin errors++; $display("FAIL reset_c_q got=%h exp=00000000", c_q); end
    checks++; if (h_rdata !== 32'h0) begin errors++; $display("FAIL reset_h_rdata got=%h exp=00000000", h_rdata); end
    @(negedge clk);
    rstn = 1'b1;
    cycle();
  endtask

  task automatic test_host_rw();
    h_valid = 1'b1; h_we = 1'b1; h_addr = 4'd5; h_bweb = 4'hF; h_d = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if (h_ready !== 1'b1) begin errors++; $display("FAIL hrw_ready_wr got=%b exp=1", h_ready); end
    cycle();
    h_we = 1'b0;
    @(negedge clk);
    checks++; if (h_ready !== 1'b1) begin errors++; $display("FAIL hrw_ready_rd got=%b exp=1", h_ready); end
    cycle();
    h_valid = 1'b0;
    checks++; if (h_rvalid !== 1'b1) begin errors++; $display("FAIL hrw_rvalid got=%b exp=1", h_rvalid); end
    checks++; if (h_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL hrw_rdata got=%h exp=deadbeef", h_rdata); end
    $display("host wr/rd addr=5 rdata=%h", h_rdata);
    cycle();
    checks++; if (h_rvalid !== 1'b0) begin errors++; $display("FAIL hrw_rvalid_pulse got=%b exp=0", h_rvalid); end
    checks++; if (h_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL hrw_rdata_hold got=%h exp=deadbeef", h_rdata); end
  endtask

  task automatic test_byte_mask();
    host_write(4'd3, 32'h11223344);
    busy = 1'b1;
    c_cs = 1'b1; c_we = 1'b1; c_addr = 4'd3; c_bweb = 4'b0101; c_d = 32'hAABBCCDD;
    cycle();
    c_we = 1'b0;
    cycle();
    c_cs = 1'b0;
    checks++; if (c_q !== 32'h11BB33DD) begin errors++; $display("FAIL byte_mask_c_q got=%h exp=11bb33dd", c_q); end
    $display("comp masked wr/rd addr=3 c_q=%h", c_q);
    busy = 1'b0;
    cycle();
  endtask

  task automatic test_arbitration();
    logic [31:0] rd;
    int ready_seen = 0;
    host_write(4'd7, 32'h12345678);
    busy = 1'b1;
    h_valid = 1'b1; h_we = 1'b1; h_addr = 4'd7; h_bweb = 4'hF; h_d = 32'h77777777;
    for (int i = 0; i < 10; i++) begin
      if (i == 9) begin
        c_cs = 1'b1; c_we = 1'b0; c_addr = 4'd7;
      end
      @(negedge clk);
      if (h_ready !== 1'b0) ready_seen++;
      cycle();
    end
    c_cs = 1'b0;
    checks++; if (ready_seen !== 0) begin errors++; $display("FAIL arb_ready_busy got=%0d cycles exp=0", ready_seen); end
    checks++; if (c_q !== 32'h12345678) begin errors++; $display("FAIL arb_no_commit got=%h exp=12345678", c_q); end
    busy = 1'b0;
    @(negedge clk);
    checks++; if (h_ready !== 1'b1) begin errors++; $display("FAIL arb_ready_after got=%b exp=1", h_ready); end
    cycle();
    h_valid = 1'b0; h_we = 1'b0;
    $display("host wr addr=7 data=77777777 after busy");
    host_read(4'd7, rd);
    checks++; if (rd !== 32'h77777777) begin errors++; $display("FAIL arb_commit_after got=%h exp=77777777", rd); end
  endtask

  // Runs a fill from a clr_req pulse; optionally re-pulses clr_req mid-sweep.
  task automatic run_fill(input bit repulse, output int busy_cnt, output int done_cnt,
                          output int done_idx, output int ready_bad);
    busy_cnt = 0; done_cnt = 0; done_idx = -1; ready_bad = 0;
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (clr_busy === 1'b1) busy_cnt++;
      if (clr_done === 1'b1) begin done_cnt++; done_idx = i; end
      if (i == 1) begin
        h_valid = 1'b1; h_we = 1'b0; h_addr = 4'd0;
        #1;
        if (h_ready !== 1'b0) ready_bad++;
        h_valid = 1'b0;
      end
      if (repulse && i == 3) clr_req = 1'b1;
      if (i == 4) clr_req = 1'b0;
      cycle();
    end
    $display("fill repulse=%0b busy_cycles=%0d done_pulses=%0d done_at=%0d", repulse, busy_cnt, done_cnt, done_idx);
  endtask

  task automatic test_zero_fill();
    int bc, dc, di, rb;
    logic [31:0] rd;
    for (int a = 0; a < DEPTH; a++) host_write(AW'(a), 32'hFFFFFFFF);
    run_fill(1'b0, bc, dc, di, rb);
    checks++; if (bc !== 16) begin errors++; $display("FAIL fill_busy_cycles got=%0d exp=16", bc); end
    checks++; if (dc !== 1) begin errors++; $display("FAIL fill_done_count got=%0d exp=1", dc); end
    checks++; if (di !== 16) begin errors++; $display("FAIL fill_done_time got=%0d exp=16", di); end
    checks++; if (rb !== 0) begin errors++; $display("FAIL fill_h_ready got=%0d exp=0", rb); end
    host_read(4'd0, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL fill_addr0 got=%h exp=00000000", rd); end
    host_read(4'd15, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL fill_addr15 got=%h exp=00000000", rd); end
  endtask

  task automatic test_ignored();
    int bc, dc, di, rb;
    logic [31:0] rd;
    host_write(4'd9, 32'hA5A5A5A5);
    busy = 1'b1; clr_req = 1'b1;
    cycle();
    clr_req = 1'b0; busy = 1'b0;
    @(negedge clk);
    checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL ign_busy_req got=%b exp=0", clr_busy); end
    cycle();
    host_read(4'd9, rd);
    checks++; if (rd !== 32'hA5A5A5A5) begin errors++; $display("FAIL ign_no_clear got=%h exp=a5a5a5a5", rd); end
    run_fill(1'b1, bc, dc, di, rb);
    checks++; if (bc !== 16) begin errors++; $display("FAIL ign_busy_cycles got=%0d exp=16", bc); end
    checks++; if (dc !== 1) begin errors++; $display("FAIL ign_done_count got=%0d exp=1", dc); end
    checks++; if (di !== 16) begin errors++; $display("FAIL ign_done_time got=%0d exp=16", di); end
    host_read(4'd9, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ign_cleared got=%h exp=00000000", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    for (int a = 0; a < DEPTH; a++) host_write(AW'(a), 32'hFFFFFFFF);
    host_read(4'd1, rd);
    busy = 1'b1; c_cs = 1'b1; c_we = 1'b0; c_addr = 4'd1;
    cycle();
    c_cs = 1'b0; busy = 1'b0;
    checks++; if (c_q !== 32'hFFFFFFFF) begin errors++; $display("FAIL rmid_c_q_pre got=%h exp=ffffffff", c_q); end
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    checks++; if (clr_busy !== 1'b1) begin errors++; $display("FAIL rmid_in_clear got=%b exp=1", clr_busy); end
    #2;
    rstn = 1'b0;
    #1;
    checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL rmid_clr_busy got=%b exp=0", clr_busy); end
    checks++; if (clr_done !== 1'b0) begin errors++; $display("FAIL rmid_clr_done got=%b exp=0", clr_done); end
    checks++; if (h_rvalid !== 1'b0) begin errors++; $display("FAIL rmid_h_rvalid got=%b exp=0", h_rvalid); end
    checks++; if (c_q !== 32'h0) begin errors++; $display("FAIL rmid_c_q got=%h exp=00000000", c_q); end
    checks++; if (h_rdata !== 32'h0) begin errors++; $display("FAIL rmid_h_rdata got=%h exp=00000000", h_rdata); end
    $display("reset asserted mid-fill");
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    cycle();
    host_read(4'd2, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rmid_addr2 got=%h exp=00000000", rd); end
    host_read(4'd10, rd);
    checks++; if (rd !== 32'hFFFFFFFF) begin errors++; $display("FAIL rmid_addr10 got=%h exp=ffffffff", rd); end
  endtask

  initial begin
    test_reset();
    test_host_rw();
    test_byte_mask();
    test_arbitration();
    test_zero_fill();
    test_ignored();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/epu_buf_responder.md
Name: epu_buf_responder

Overview:
- Memory-side responder for one EPU buffer (param, bias, weight, input or output) on the single-port SRAM protocol that the conv, maxpool and fc engines drive as initiators.
- Owns the storage array and arbitrates between two masters: the compute engine, which has no stall path, and a host/DMA port with a valid/ready handshake.
- Adds a hardware zero-fill sequencer that clears the buffer between layers.
- One instance per buffer; the instances sit between the EPU top-level bus interface and the accelerator core.

Parameters:
- DEPTH, 1024, number of 32-bit words; must be a power of two, at least 2.
- AW, $clog2(DEPTH), word address width.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- busy  in  1  high while the accelerator is running; the compute port owns the array
- c_cs  in  1  compute chip select
- c_we  in  1  compute write enable (1 = write)
- c_addr  in  AW  compute word address
- c_bweb  in  4  compute byte write-enable, active-high per byte
- c_d  in  32  compute write data
- c_q  out  32  compute read data
- h_valid  in  1  host request valid
- h_ready  out  1  host request accepted this cycle
- h_we  in  1  host write enable
- h_addr  in  AW  host word address
- h_bweb  in  4  host byte enables
- h_d  in  32  host write data
- h_rvalid  out  1  host read-data valid pulse
- h_rdata  out  32  host read data
- clr_req  in  1  start zero-fill pulse
- clr_busy  out  1  zero-fill in progress
- clr_done  out  1  one-cycle pulse when zero-fill completes

Behaviour:
Reset:
- All outputs are 0 and the FSM is in IDLE.
- Array contents are undefined after reset.

FSM states: IDLE, CLEAR.
- IDLE -> CLEAR on clr_req while busy = 0.
- clr_req while busy = 1 is ignored; no pulse is recorded.
- CLEAR writes 32'h0 with all bytes enabled to address clr_ptr, one address per cycle, from 0 to DEPTH-1.
- CLEAR -> IDLE after the write to DEPTH-1. clr_done pulses in the cycle after that write, so the fill takes DEPTH cycles from the clr_req edge to the last write.
- clr_busy = 1 throughout CLEAR.
- clr_req arriving during CLEAR is ignored; the sweep does not restart.

Arbitration, evaluated each cycle in priority order:
1. CLEAR owns the array. h_ready = 0. Compute accesses are dropped and c_q holds its value.
2. busy = 1: the compute port owns the array and h_ready = 0.
3. Otherwise the host owns the array, with h_ready = h_valid.
- Compute accesses with busy = 0 are dropped and c_q holds.
- The host handshake completes when h_valid & h_ready. The host must hold its request stable until then.

Access timing:
- Read latency is 1 cycle on both ports.
  - c_q updates in the cycle after c_cs & ~c_we.
  - h_rvalid pulses with h_rdata in the cycle after an accepted host read.
- c_q and h_rdata hold their last read value otherwise; they are never cleared by writes.
- Writes commit at the clock edge. Only bytes with bweb[i] = 1 change.
- Read-after-write to the same address on the next cycle returns the new data. Same-cycle read and write cannot occur on a single port.
- Address wrap-around: none. Addresses are AW bits, so every value is in range.

busy edge cases:
- busy rising in the same cycle as a pending host request: the host is not accepted (h_ready = 0) and waits until busy falls.
- busy falling: the host may be accepted in that same cycle.

Reset mid-operation:
- Asserting rstn low during CLEAR aborts the fill immediately.
- clr_busy and clr_done go to 0, and partially cleared contents remain.

Decomposition:
- Package epu_buf_pkg holds:
  - clr_state_e enum (IDLE, CLEAR);
  - constants BYTE_W = 8 and NBYTE = 4;
  - owner_e enum (OWN_CLR, OWN_COMP, OWN_HOST) for the arbiter select.
- Sub-module epu_buf_array: a behavioural single-port DEPTH x 32 array with cs, we, addr, bweb, d and a registered q.
  - It is replaceable by an SRAM macro wrapper.
  - The responder muxes owner signals into it and steers q to c_q or h_rdata using an owner tag registered one cycle.

Test Plan:
1. Host write then read:
   - Stimulus: busy = 0; host writes 0xDEADBEEF to addr 5 with bweb = 4'hF; then host reads addr 5.
   - Response: h_ready = 1 on both requests. h_rvalid pulses 1 cycle after the read with h_rdata = 0xDEADBEEF.
2. Byte mask on the compute port:
   - Stimulus: preload addr 3 = 0x11223344; busy = 1; compute writes 0xAABBCCDD to addr 3 with bweb = 4'b0101; then compute reads addr 3.
   - Response: c_q = 0x11BB33DD one cycle after the read.
3. Arbitration:
   - Stimulus: host h_valid = 1 held while busy = 1 for 10 cycles.
   - Response: h_ready = 0 for all 10 cycles, and the host write to addr 7 is not committed. In the first cycle after busy falls, h_ready = 1.
4. Zero-fill:
   - Stimulus: DEPTH = 16, array preloaded with 0xFFFFFFFF; pulse clr_req.
   - Response: clr_busy is high for 16 cycles; clr_done pulses once, 1 cycle after the last write; host reads of addr 0 and addr 15 return 0.
5. Ignored requests:
   - Stimulus: clr_req with busy = 1; separately, a second clr_req during CLEAR.
   - Response: the first causes no CLEAR entry. The second produces exactly one clr_done, with the total fill still 16 cycles.
6. Reset mid-operation:
   - Stimulus: DEPTH = 16, array preloaded with 0xFFFFFFFF; pull rstn low 5 cycles into CLEAR.
   - Response: clr_busy, clr_done, h_rvalid, c_q and h_rdata are 0 immediately (asynchronously). Addr 2 reads 0 and addr 10 reads 0xFFFFFFFF.
